fabric_arbiter: RTL and testbench

FABRIC_ARBITER -- requirements
Module: fabric_arbiter

---
 rtl/fabric_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_fabric_arbiter.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_arbiter.sv
// fabric_arbiter: per-channel round-robin arbiter for a NUM_SRC x NUM_DST crossbar.
// Broadcast masks are served one channel at a time; define FABRIC_ARB_TIMEOUT_EN for the grant-hold watchdog.
module fabric_arbiter #(
    parameter int unsigned NUM_SRC        = 28,
    parameter int unsigned NUM_DST        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2048,
    localparam int unsigned SRC_BITS      = $clog2(NUM_SRC),
    localparam int unsigned DST_BITS      = $clog2(NUM_DST)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          req_valid,
    input  logic [NUM_SRC*NUM_DST-1:0]  req_dst_mask,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_DST-1:0]          grant_valid,
    output logic [NUM_DST*SRC_BITS-1:0] grant_src,
    output logic [NUM_SRC-1:0]          src_grant,
    output logic [NUM_SRC*DST_BITS-1:0] src_grant_dst,
    output logic [NUM_SRC-1:0]          src_next,
    output logic [NUM_SRC-1:0]          src_done,
    output logic [NUM_DST-1:0]          err_timeout
);

    logic [NUM_SRC-1:0]  loaded_q, loaded_d;
    logic [NUM_DST-1:0]  pending_q [NUM_SRC];
    logic [NUM_DST-1:0]  pending_d [NUM_SRC];
    logic [NUM_DST-1:0]  gv_q, gv_d;
    logic [SRC_BITS-1:0] gsrc_q [NUM_DST];
    logic [SRC_BITS-1:0] gsrc_d [NUM_DST];
    logic [SRC_BITS-1:0] rr_q [NUM_DST];
    logic [SRC_BITS-1:0] rr_d [NUM_DST];
    logic [NUM_SRC-1:0]  sg_q, sg_d;
    logic [DST_BITS-1:0] sgd_q [NUM_SRC];
    logic [DST_BITS-1:0] sgd_d [NUM_SRC];
    logic [NUM_SRC-1:0]  next_q, next_d;
    logic [NUM_SRC-1:0]  done_q, done_d;
    logic [NUM_DST-1:0]  tmo_q, tmo_d;

    logic [NUM_SRC-1:0]  elig;
    logic [NUM_DST-1:0]  expire;
    logic [NUM_SRC-1:0]  taken;
    logic [NUM_DST-1:0]  rem;
    logic                found;
    int unsigned         idx;
    logic [SRC_BITS-1:0] sidx;

    // A source competes only while loaded, still requesting and not already holding a channel.
    assign elig = loaded_q & req_valid & ~sg_q;

`ifdef FABRIC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_BITS-1:0] cnt_q [NUM_DST];

    // Counts completed owned cycles; restarts whenever the channel is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_DST; d++) cnt_q[d] <= '0;
        end else begin
            for (int d = 0; d < NUM_DST; d++) begin
                if (!gv_q[d]) cnt_q[d] <= '0;
                else          cnt_q[d] <= cnt_q[d] + 1'b1;
            end
        end
    end

    always_comb begin
        expire = '0;
        for (int d = 0; d < NUM_DST; d++) begin
            expire[d] = gv_q[d] && (cnt_q[d] == CNT_BITS'(TIMEOUT_CYCLES - 1));
        end
    end
`else
    assign expire = '0;
`endif

    always_comb begin
        loaded_d  = loaded_q;
        pending_d = pending_q;
        gv_d      = gv_q;
        gsrc_d    = gsrc_q;
        rr_d      = rr_q;
        sg_d      = sg_q;
        sgd_d     = sgd_q;
        next_d    = '0;
        done_d    = '0;
        tmo_d     = '0;
        taken     = '0;
        rem       = '0;
        found     = 1'b0;
        idx       = '0;
        sidx      = '0;

        // Per-source abort, release, empty-mask completion and load.
        for (int s = 0; s < NUM_SRC; s++) begin
            if (loaded_q[s] && !req_valid[s]) begin
                loaded_d[s]  = 1'b0;
                pending_d[s] = '0;
                if (sg_q[s]) begin
                    sg_d[s]           = 1'b0;
                    sgd_d[s]          = '0;
                    gv_d[sgd_q[s]]    = 1'b0;
                    gsrc_d[sgd_q[s]]  = '0;
                end
            end else if (sg_q[s] && (src_last[s] || expire[sgd_q[s]])) begin
                rem               = pending_q[s] & ~(NUM_DST'(1) << sgd_q[s]);
                pending_d[s]      = rem;
                sg_d[s]           = 1'b0;
                sgd_d[s]          = '0;
                gv_d[sgd_q[s]]    = 1'b0;
                gsrc_d[sgd_q[s]]  = '0;
                tmo_d[sgd_q[s]]   = !src_last[s];
                if (rem == '0) begin
                    done_d[s]   = 1'b1;
                    loaded_d[s] = 1'b0;
                end else begin
                    next_d[s] = 1'b1;
                end
            end else if (loaded_q[s] && !sg_q[s] && (pending_q[s] == '0)) begin
                done_d[s]   = 1'b1;
                loaded_d[s] = 1'b0;
            end else if (!loaded_q[s] && req_valid[s]) begin
                loaded_d[s]  = 1'b1;
                pending_d[s] = req_dst_mask[s*NUM_DST +: NUM_DST];
            end
        end

        // Free channels search round-robin; lower channels claim a source first.
        for (int d = 0; d < NUM_DST; d++) begin
            if (!gv_q[d]) begin
                found = 1'b0;
                for (int unsigned k = 0; k < NUM_SRC; k++) begin
                    idx = 32'(rr_q[d]) + k;
                    if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                    sidx = SRC_BITS'(idx);
                    if (!found && elig[sidx] && pending_q[sidx][d] && !taken[sidx]) begin
                        found       = 1'b1;
                        taken[sidx] = 1'b1;
                        gv_d[d]     = 1'b1;
                        gsrc_d[d]   = sidx;
                        sg_d[sidx]  = 1'b1;
                        sgd_d[sidx] = DST_BITS'(d);
                        rr_d[d]     = (sidx == SRC_BITS'(NUM_SRC - 1)) ? '0 : sidx + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= '0;
            gv_q     <= '0;
            sg_q     <= '0;
            next_q   <= '0;
            done_q   <= '0;
            tmo_q    <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                pending_q[s] <= '0;
                sgd_q[s]     <= '0;
            end
            for (int d = 0; d < NUM_DST; d++) begin
                gsrc_q[d] <= '0;
                rr_q[d]   <= '0;
            end
        end else begin
            loaded_q  <= loaded_d;
            pending_q <= pending_d;
            gv_q      <= gv_d;
            gsrc_q    <= gsrc_d;
            rr_q      <= rr_d;
            sg_q      <= sg_d;
            sgd_q     <= sgd_d;
            next_q    <= next_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    assign grant_valid = gv_q;
    assign src_grant   = sg_q;
    assign src_next    = next_q;
    assign src_done    = done_q;
    assign err_timeout = tmo_q;

    for (genvar g = 0; g < NUM_DST; g++) begin : g_dst
        assign grant_src[g*SRC_BITS +: SRC_BITS] = gsrc_q[g];
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_grant_dst[g*DST_BITS +: DST_BITS] = sgd_q[g];
    end

endmodule

// File: tb/tb_fabric_arbiter.sv
// Self-checking bench for fabric_arbiter: expected grants are queued as stimulus is driven
// and popped by a negedge monitor; each scenario task checks pulses and ownership inline.
module tb_fabric_arbiter;

    localparam int unsigned NS = 28;
    localparam int unsigned ND = 8;
    localparam int unsigned SB = 5;
    localparam int unsigned DB = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NS-1:0]    req_valid = '0;
    logic [NS*ND-1:0] req_dst_mask = '0;
    logic [NS-1:0]    src_last = '0;
    logic [ND-1:0]    grant_valid;
    logic [ND*SB-1:0] grant_src;
    logic [NS-1:0]    src_grant;
    logic [NS*DB-1:0] src_grant_dst;
    logic [NS-1:0]    src_next;
    logic [NS-1:0]    src_done;
    logic [ND-1:0]    err_timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned dst;
        int unsigned src;
    } exp_t;
    exp_t exp_q[$];
    logic [ND-1:0] prev_gv = '0;

    always #5 clk = ~clk;

    fabric_arbiter #(.NUM_SRC(NS), .NUM_DST(ND), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dst_mask  (req_dst_mask),
        .src_last      (src_last),
        .grant_valid   (grant_valid),
        .grant_src     (grant_src),
        .src_grant     (src_grant),
        .src_grant_dst (src_grant_dst),
        .src_next      (src_next),
        .src_done      (src_done),
        .err_timeout   (err_timeout)
    );

    function automatic int unsigned gsrc(input int unsigned d);
        return 32'(grant_src[d*SB +: SB]);
    endfunction

    function automatic int unsigned sdst(input int unsigned s);
        return 32'(src_grant_dst[s*DB +: DB]);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int unsigned s, input logic [ND-1:0] m);
        req_valid[s] = 1'b1;
        req_dst_mask[s*ND +: ND] = m;
    endtask

    task automatic drop_req(input int unsigned s);
        req_valid[s] = 1'b0;
        req_dst_mask[s*ND +: ND] = '0;
    endtask

    task automatic expect_grant(input int unsigned d, input int unsigned s);
        exp_t e;
        e.dst = d;
        e.src = s;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every new grant must match the head of the queue; ownership views must agree.
    always @(negedge clk) begin
        exp_t e;
        logic bad;
        for (int d = 0; d < ND; d++) begin
            if (grant_valid[d] && !prev_gv[d]) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_order: ch%0d src%0d granted, none expected", d, gsrc(d));
                end else begin
                    e = exp_q.pop_front();
                    if (e.dst != d || e.src != gsrc(d)) begin
                        miscompares++;
                        $display("FAIL grant_order: got ch%0d src%0d want ch%0d src%0d", d, gsrc(d), e.dst, e.src);
                    end
                end
            end
        end
        bad = ($countones(grant_valid) != $countones(src_grant));
        for (int d = 0; d < ND; d++) begin
            if (grant_valid[d] && (!src_grant[gsrc(d)] || sdst(gsrc(d)) != d)) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL ownership: grant_valid=%h src_grant=%h want one channel per source", grant_valid, src_grant);
        end
        prev_gv = grant_valid;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (grant_valid !== '0 || grant_src !== '0) begin
            miscompares++;
            $display("FAIL reset_grant: got v=%h src=%h want 0", grant_valid, grant_src);
        end
        vectors++;
        if (src_grant !== '0 || src_grant_dst !== '0) begin
            miscompares++;
            $display("FAIL reset_src_grant: got %h/%h want 0", src_grant, src_grant_dst);
        end
        vectors++;
        if (src_next !== '0 || src_done !== '0 || err_timeout !== '0) begin
            miscompares++;
            $display("FAIL reset_pulses: got next=%h done=%h tmo=%h want 0", src_next, src_done, err_timeout);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (grant_valid !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want 0", grant_valid);
        end
    endtask

    task automatic test_unicast();
        set_req(3, 8'h04);
        expect_grant(2, 3);
        tick();
        vectors++;
        if (grant_valid !== '0) begin
            miscompares++;
            $display("FAIL unicast_load_edge: got %h want 00", grant_valid);
        end
        tick();
        vectors++;
        if (grant_valid !== 8'h04 || gsrc(2) != 3 || src_grant[3] !== 1'b1 || sdst(3) != 2) begin
            miscompares++;
            $display("FAIL unicast_grant: got v=%h src=%0d sg=%b sdst=%0d want 04/3/1/2", grant_valid, gsrc(2), src_grant[3], sdst(3));
        end
        tick();
        vectors++;
        if (grant_valid[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL unicast_hold: got %b want 1", grant_valid[2]);
        end
        src_last[3] = 1'b1;
        tick();
        src_last[3] = 1'b0;
        drop_req(3);
        vectors++;
        if (src_done[3] !== 1'b1 || src_next[3] !== 1'b0 || grant_valid[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL unicast_release: got done=%b next=%b v=%b want 1/0/0", src_done[3], src_next[3], grant_valid[2]);
        end
        tick();
        vectors++;
        if (src_done !== '0) begin
            miscompares++;
            $display("FAIL unicast_done_once: got %h want 0", src_done);
        end
    endtask

    task automatic test_contention();
        int unsigned own1 [3] = '{0, 5, 27};
        int unsigned own2 [2] = '{0, 27};
        for (int i = 0; i < 3; i++) begin
            set_req(own1[i], 8'h01);
            expect_grant(0, own1[i]);
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (grant_valid[0] !== 1'b1 || gsrc(0) != own1[i]) begin
                miscompares++;
                $display("FAIL contention_owner%0d: got v=%b src=%0d want 1/%0d", i, grant_valid[0], gsrc(0), own1[i]);
            end
            src_last[own1[i]] = 1'b1;
            tick();
            src_last[own1[i]] = 1'b0;
            drop_req(own1[i]);
            vectors++;
            if (src_done[own1[i]] !== 1'b1 || grant_valid[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL contention_bubble%0d: got done=%b v=%b want 1/0", i, src_done[own1[i]], grant_valid[0]);
            end
            tick();
        end
        vectors++;
        if (grant_valid !== '0) begin
            miscompares++;
            $display("FAIL contention_drained: got %h want 0", grant_valid);
        end
        // Pointer must have wrapped to 0, so source 0 beats source 27 next round.
        set_req(27, 8'h01);
        set_req(0, 8'h01);
        expect_grant(0, 0);
        expect_grant(0, 27);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (grant_valid[0] !== 1'b1 || gsrc(0) != own2[i]) begin
                miscompares++;
                $display("FAIL contention_wrap%0d: got v=%b src=%0d want 1/%0d", i, grant_valid[0], gsrc(0), own2[i]);
            end
            src_last[own2[i]] = 1'b1;
            tick();
            src_last[own2[i]] = 1'b0;
            drop_req(own2[i]);
            tick();
        end
    endtask

    task automatic test_broadcast();
        int unsigned chs [3] = '{0, 1, 3};
        int n_next = 0;
        int n_done = 0;
        set_req(1, 8'h0B);
        for (int i = 0; i < 3; i++) expect_grant(chs[i], 1);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (grant_valid[chs[i]] !== 1'b1 || gsrc(chs[i]) != 1 || src_grant[1] !== 1'b1 || sdst(1) != chs[i]) begin
                miscompares++;
                $display("FAIL broadcast_copy%0d: got v=%h src=%0d sdst=%0d want ch%0d src1", i, grant_valid, gsrc(chs[i]), sdst(1), chs[i]);
            end
            src_last[1] = 1'b1;
            tick();
            src_last[1] = 1'b0;
            n_next += int'(src_next[1]);
            n_done += int'(src_done[1]);
            vectors++;
            if (grant_valid !== '0 || src_grant[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL broadcast_gap%0d: got v=%h sg=%b want 00/0", i, grant_valid, src_grant[1]);
            end
            if (i == 2) drop_req(1);
            tick();
        end
        vectors++;
        if (n_next != 2 || n_done != 1) begin
            miscompares++;
            $display("FAIL broadcast_pulses: got next=%0d done=%0d want 2/1", n_next, n_done);
        end
        vectors++;
        if (src_done[1] !== 1'b0 || grant_valid !== '0) begin
            miscompares++;
            $display("FAIL broadcast_quiet: got done=%b v=%h want 0/00", src_done[1], grant_valid);
        end
    endtask

    task automatic test_conflict();
        set_req(2, 8'h03);
        set_req(4, 8'h03);
        expect_grant(0, 2);
        expect_grant(1, 4);
        expect_grant(0, 4);
        expect_grant(1, 2);
        tick();
        tick();
        vectors++;
        if (grant_valid !== 8'h03 || gsrc(0) != 2 || gsrc(1) != 4) begin
            miscompares++;
            $display("FAIL conflict_first: got v=%h ch0=%0d ch1=%0d want 03/2/4", grant_valid, gsrc(0), gsrc(1));
        end
        src_last[2] = 1'b1;
        src_last[4] = 1'b1;
        tick();
        src_last[2] = 1'b0;
        src_last[4] = 1'b0;
        vectors++;
        if (src_next[2] !== 1'b1 || src_next[4] !== 1'b1 || grant_valid !== '0) begin
            miscompares++;
            $display("FAIL conflict_next: got next2=%b next4=%b v=%h want 1/1/00", src_next[2], src_next[4], grant_valid);
        end
        tick();
        vectors++;
        if (grant_valid !== 8'h03 || gsrc(0) != 4 || gsrc(1) != 2) begin
            miscompares++;
            $display("FAIL conflict_second: got v=%h ch0=%0d ch1=%0d want 03/4/2", grant_valid, gsrc(0), gsrc(1));
        end
        src_last[2] = 1'b1;
        src_last[4] = 1'b1;
        tick();
        src_last[2] = 1'b0;
        src_last[4] = 1'b0;
        drop_req(2);
        drop_req(4);
        vectors++;
        if (src_done[2] !== 1'b1 || src_done[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_done: got done2=%b done4=%b want 1/1", src_done[2], src_done[4]);
        end
        tick();
    endtask

    task automatic test_zero_mask();
        set_req(9, 8'h00);
        tick();
        vectors++;
        if (src_done[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_mask_early: got %b want 0", src_done[9]);
        end
        tick();
        drop_req(9);
        vectors++;
        if (src_done[9] !== 1'b1 || grant_valid !== '0 || src_grant !== '0) begin
            miscompares++;
            $display("FAIL zero_mask_done: got done=%b v=%h sg=%h want 1/00/0", src_done[9], grant_valid, src_grant);
        end
        tick();
    endtask

    task automatic test_abort();
        set_req(6, 8'h10);
        expect_grant(4, 6);
        tick();
        tick();
        vectors++;
        if (grant_valid[4] !== 1'b1 || gsrc(4) != 6) begin
            miscompares++;
            $display("FAIL abort_grant: got v=%b src=%0d want 1/6", grant_valid[4], gsrc(4));
        end
        src_last[7] = 1'b1;
        tick();
        src_last[7] = 1'b0;
        vectors++;
        if (grant_valid[4] !== 1'b1 || src_done[7] !== 1'b0 || src_next[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_last: got v=%b done7=%b next7=%b want 1/0/0", grant_valid[4], src_done[7], src_next[7]);
        end
        drop_req(6);
        tick();
        vectors++;
        if (grant_valid[4] !== 1'b0 || src_grant[6] !== 1'b0 || src_done[6] !== 1'b0 || src_next[6] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_release: got v=%b sg=%b done=%b next=%b want 0/0/0/0", grant_valid[4], src_grant[6], src_done[6], src_next[6]);
        end
        tick();
    endtask

    task automatic test_timeout();
        set_req(10, 8'h20);
        set_req(11, 8'h20);
        expect_grant(5, 10);
        expect_grant(5, 11);
        tick();
        tick();
        vectors++;
        if (grant_valid[5] !== 1'b1 || gsrc(5) != 10) begin
            miscompares++;
            $display("FAIL timeout_grant: got v=%b src=%0d want 1/10", grant_valid[5], gsrc(5));
        end
`ifdef FABRIC_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            vectors++;
            if (err_timeout !== '0 || grant_valid[5] !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_hold%0d: got tmo=%h v=%b want 00/1", i, err_timeout, grant_valid[5]);
            end
        end
        tick();
        drop_req(10);
        vectors++;
        if (err_timeout !== 8'h20 || grant_valid[5] !== 1'b0 || src_done[10] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire: got tmo=%h v=%b done=%b want 20/0/1", err_timeout, grant_valid[5], src_done[10]);
        end
`else
        for (int i = 1; i < 40; i++) begin
            tick();
            vectors++;
            if (err_timeout !== '0 || grant_valid[5] !== 1'b1 || gsrc(5) != 10) begin
                miscompares++;
                $display("FAIL hold_forever%0d: got tmo=%h v=%b src=%0d want 00/1/10", i, err_timeout, grant_valid[5], gsrc(5));
            end
        end
        src_last[10] = 1'b1;
        tick();
        src_last[10] = 1'b0;
        drop_req(10);
`endif
        tick();
        vectors++;
        if (err_timeout !== '0 || grant_valid[5] !== 1'b1 || gsrc(5) != 11) begin
            miscompares++;
            $display("FAIL timeout_regrant: got tmo=%h v=%b src=%0d want 00/1/11", err_timeout, grant_valid[5], gsrc(5));
        end
        src_last[11] = 1'b1;
        tick();
        src_last[11] = 1'b0;
        drop_req(11);
        vectors++;
        if (src_done[11] !== 1'b1 || err_timeout !== '0) begin
            miscompares++;
            $display("FAIL timeout_normal_release: got done=%b tmo=%h want 1/00", src_done[11], err_timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(1, 8'h0B);
        expect_grant(0, 1);
        expect_grant(1, 1);
        tick();
        tick();
        src_last[1] = 1'b1;
        tick();
        src_last[1] = 1'b0;
        tick();
        vectors++;
        if (grant_valid[1] !== 1'b1 || gsrc(1) != 1) begin
            miscompares++;
            $display("FAIL reset_mid_setup: got v=%h src=%0d want ch1 src1", grant_valid, gsrc(1));
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (grant_valid !== '0 || grant_src !== '0 || src_grant !== '0 || src_grant_dst !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_grant: got v=%h src=%h sg=%h sdst=%h want 0", grant_valid, grant_src, src_grant, src_grant_dst);
        end
        vectors++;
        if (src_next !== '0 || src_done !== '0 || err_timeout !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_pulses: got next=%h done=%h tmo=%h want 0", src_next, src_done, err_timeout);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_grant(0, 1);
        tick();
        vectors++;
        if (grant_valid !== '0 || src_done[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_load: got v=%h done=%b want 00/0", grant_valid, src_done[1]);
        end
        tick();
        vectors++;
        if (grant_valid !== 8'h01 || gsrc(0) != 1) begin
            miscompares++;
            $display("FAIL reset_mid_restart: got v=%h src=%0d want 01/1", grant_valid, gsrc(0));
        end
        drop_req(1);
        tick();
        vectors++;
        if (grant_valid !== '0 || src_done !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: got v=%h done=%h want 0", grant_valid, src_done);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_contention();
        test_broadcast();
        test_conflict();
        test_zero_mask();
        test_abort();
        test_timeout();
        test_reset_mid();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL grants_outstanding: got %0d queued want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
